// File: rtl/xalu_ise_arb_pkg.sv
// Shared types for the ISE ALU arbiter: sequencer state encoding, custom opcode
// selectors and requester id width.
package xalu_ise_arb_pkg;

   localparam int ID_W = 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // fn[1:0] picks one of the four RISC-V custom major opcodes
   typedef enum logic [1:0] {
      CUSTOM_0 = 2'd0,
      CUSTOM_1 = 2'd1,
      CUSTOM_2 = 2'd2,
      CUSTOM_3 = 2'd3
   } custom_e;

endpackage

// File: rtl/xalu_rr_arb2.sv
// Combinational 2-way round-robin grant: a lone requester wins outright,
// a contested cycle goes to the requester that was not served last.
module xalu_rr_arb2
   import xalu_ise_arb_pkg::*;
(
   input  logic [1:0]      req,
   input  logic [ID_W-1:0] last,
   output logic [1:0]      gnt,
   output logic [ID_W-1:0] gnt_id
);

   always_comb begin
      gnt    = 2'b00;
      gnt_id = '0;
      case (req)
         2'b01: gnt = 2'b01;
         2'b10: begin
            gnt    = 2'b10;
            gnt_id = 1'b1;
         end
         2'b11: begin
            if (last == 1'b0) begin
               gnt    = 2'b10;
               gnt_id = 1'b1;
            end else begin
               gnt = 2'b01;
            end
         end
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/xalu_ise_arb.sv
// Two-requester sequencer in front of the shared ISE ALU: grant, drive the ALU
// for one cycle from registered operands, then hold the result until accepted.
//
//   state | meaning
//   IDLE  | arbitrate; latch granted operands on the handshake
//   EXEC  | ALU driven from latched operands, result/err captured
//   RESP  | result presented to source requester until rsp_rdy
module xalu_ise_arb
   import xalu_ise_arb_pkg::*;
#(
   parameter int   XLEN    = 64,
   parameter logic RR_INIT = 1'b1
) (
   input  logic            ise_clk,
   input  logic            ise_rst,

   input  logic            r0_req_val,
   output logic            r0_req_rdy,
   input  logic [4:0]      r0_fn,
   input  logic [6:0]      r0_imm,
   input  logic [XLEN-1:0] r0_in1,
   input  logic [XLEN-1:0] r0_in2,
   output logic            r0_rsp_val,
   input  logic            r0_rsp_rdy,
   output logic [XLEN-1:0] r0_rsp_out,
   output logic            r0_rsp_err,

   input  logic            r1_req_val,
   output logic            r1_req_rdy,
   input  logic [4:0]      r1_fn,
   input  logic [6:0]      r1_imm,
   input  logic [XLEN-1:0] r1_in1,
   input  logic [XLEN-1:0] r1_in2,
   output logic            r1_rsp_val,
   input  logic            r1_rsp_rdy,
   output logic [XLEN-1:0] r1_rsp_out,
   output logic            r1_rsp_err,

   output logic [4:0]      x_fn,
   output logic [6:0]      x_imm,
   output logic [XLEN-1:0] x_in1,
   output logic [XLEN-1:0] x_in2,
   output logic            x_val,
   input  logic            x_oval,
   input  logic [XLEN-1:0] x_out
);

   state_e            state_q, state_d;
   logic [ID_W-1:0]   src_q, src_d;
   logic [ID_W-1:0]   last_q, last_d;
   logic [4:0]        fn_q, fn_d;
   logic [6:0]        imm_q, imm_d;
   logic [XLEN-1:0]   in1_q, in1_d;
   logic [XLEN-1:0]   in2_q, in2_d;
   logic [XLEN-1:0]   res_q, res_d;
   logic              err_q, err_d;

   logic [1:0]        gnt;
   logic [ID_W-1:0]   gnt_id;
   logic              src_rsp_rdy;

   xalu_rr_arb2 u_arb (
      .req    ({r1_req_val, r0_req_val}),
      .last   (last_q),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   always_comb begin
      state_d     = state_q;
      src_d       = src_q;
      last_d      = last_q;
      fn_d        = fn_q;
      imm_d       = imm_q;
      in1_d       = in1_q;
      in2_d       = in2_q;
      res_d       = res_q;
      err_d       = err_q;
      r0_req_rdy  = 1'b0;
      r1_req_rdy  = 1'b0;
      x_val       = 1'b0;
      src_rsp_rdy = (src_q == 1'b1) ? r1_rsp_rdy : r0_rsp_rdy;

      case (state_q)
         ST_IDLE: begin
            r0_req_rdy = gnt[0];
            r1_req_rdy = gnt[1];
            if (|gnt) begin
               src_d   = gnt_id;
               fn_d    = (gnt_id == 1'b1) ? r1_fn  : r0_fn;
               imm_d   = (gnt_id == 1'b1) ? r1_imm : r0_imm;
               in1_d   = (gnt_id == 1'b1) ? r1_in1 : r0_in1;
               in2_d   = (gnt_id == 1'b1) ? r1_in2 : r0_in2;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            x_val   = 1'b1;
            res_d   = x_out;
            err_d   = ~x_oval;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (src_rsp_rdy) begin
               last_d  = src_q;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Response channels are gated so the non-source requester always reads 0
   assign r0_rsp_val = (state_q == ST_RESP) && (src_q == 1'b0);
   assign r1_rsp_val = (state_q == ST_RESP) && (src_q == 1'b1);
   assign r0_rsp_out = r0_rsp_val ? res_q : '0;
   assign r1_rsp_out = r1_rsp_val ? res_q : '0;
   assign r0_rsp_err = r0_rsp_val & err_q;
   assign r1_rsp_err = r1_rsp_val & err_q;

   assign x_fn  = fn_q;
   assign x_imm = imm_q;
   assign x_in1 = in1_q;
   assign x_in2 = in2_q;

   always_ff @(posedge ise_clk) begin
      if (ise_rst) begin
         state_q <= ST_IDLE;
         src_q   <= '0;
         last_q  <= RR_INIT;
         fn_q    <= '0;
         imm_q   <= '0;
         in1_q   <= '0;
         in2_q   <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         last_q  <= last_d;
         fn_q    <= fn_d;
         imm_q   <= imm_d;
         in1_q   <= in1_d;
         in2_q   <= in2_d;
         res_q   <= res_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_xalu_ise_arb.sv
// Bench for xalu_ise_arb: cycle table, directed reset/isolation sequences and
// a randomized run against a transaction-level model of the arbiter.
module tb_xalu_ise_arb;

   logic        ise_clk, ise_rst;
   logic        r0_req_val, r0_req_rdy, r0_rsp_val, r0_rsp_rdy, r0_rsp_err;
   logic [4:0]  r0_fn;
   logic [6:0]  r0_imm;
   logic [63:0] r0_in1, r0_in2, r0_rsp_out;
   logic        r1_req_val, r1_req_rdy, r1_rsp_val, r1_rsp_rdy, r1_rsp_err;
   logic [4:0]  r1_fn;
   logic [6:0]  r1_imm;
   logic [63:0] r1_in1, r1_in2, r1_rsp_out;
   logic [4:0]  x_fn;
   logic [6:0]  x_imm;
   logic [63:0] x_in1, x_in2, x_out;
   logic        x_val, x_oval;

   int n_pass = 0;
   int n_total = 0;

   xalu_ise_arb #(.XLEN(64), .RR_INIT(1'b1)) dut (
      .ise_clk(ise_clk), .ise_rst(ise_rst),
      .r0_req_val(r0_req_val), .r0_req_rdy(r0_req_rdy), .r0_fn(r0_fn), .r0_imm(r0_imm),
      .r0_in1(r0_in1), .r0_in2(r0_in2), .r0_rsp_val(r0_rsp_val), .r0_rsp_rdy(r0_rsp_rdy),
      .r0_rsp_out(r0_rsp_out), .r0_rsp_err(r0_rsp_err),
      .r1_req_val(r1_req_val), .r1_req_rdy(r1_req_rdy), .r1_fn(r1_fn), .r1_imm(r1_imm),
      .r1_in1(r1_in1), .r1_in2(r1_in2), .r1_rsp_val(r1_rsp_val), .r1_rsp_rdy(r1_rsp_rdy),
      .r1_rsp_out(r1_rsp_out), .r1_rsp_err(r1_rsp_err),
      .x_fn(x_fn), .x_imm(x_imm), .x_in1(x_in1), .x_in2(x_in2), .x_val(x_val),
      .x_oval(x_oval), .x_out(x_out)
   );

   initial ise_clk = 1'b0;
   always #5 ise_clk = ~ise_clk;

   // Stand-in ALU: imm 7'h7F is the one unsupported encoding and returns 0
   function automatic logic [63:0] alu_ref(input logic [4:0] fn, input logic [6:0] imm,
                                           input logic [63:0] a, input logic [63:0] b);
      if (imm == 7'h7F) return 64'd0;
      return a ^ {b[31:0], b[63:32]} ^ {52'd0, fn, imm};
   endfunction

   assign x_oval = (x_imm != 7'h7F);
   assign x_out  = alu_ref(x_fn, x_imm, x_in1, x_in2);

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
      else n_pass++;
   endtask

   task automatic step();
      @(posedge ise_clk);
      #1;
   endtask

   typedef struct {
      logic rst, r0v, r1v, r0rr, r1rr;
      logic e0rdy, e1rdy, exval, e0val, e1val;
   } vec_t;

   localparam logic [63:0] R0_RES = 64'hDEADBEEF00000001;

   vec_t tbl[18];

   // model state for the random phase
   bit          m_busy, m_owner, m_last;
   int          m_age;
   logic [4:0]  m_fn;
   logic [6:0]  m_imm;
   logic [63:0] m_in1, m_in2;

   initial begin
      logic [63:0] a_val, b_val, eres;
      bit g0, g1, ev, rv;

      ise_rst = 1'b1;
      r0_req_val = 0; r0_rsp_rdy = 0; r0_fn = 5'b00011; r0_imm = 7'b0100000;
      r0_in1 = 64'hDEADBEEF000001A1; r0_in2 = 64'd0;
      r1_req_val = 0; r1_rsp_rdy = 0; r1_fn = 5'b00001; r1_imm = 7'h7F;
      r1_in1 = 64'h5555AAAA5555AAAA; r1_in2 = 64'h0F0F0F0F0F0F0F0F;

      //            rst r0v r1v r0rr r1rr | e0rdy e1rdy xval e0val e1val
      tbl[0]  = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 0};
      tbl[1]  = '{0, 1, 1, 0, 0,  1, 0, 0, 0, 0};
      tbl[2]  = '{0, 1, 1, 0, 0,  0, 0, 1, 0, 0};
      tbl[3]  = '{0, 1, 1, 0, 0,  0, 0, 0, 1, 0};
      tbl[4]  = '{0, 1, 1, 1, 0,  0, 0, 0, 1, 0};
      tbl[5]  = '{0, 1, 1, 0, 0,  0, 1, 0, 0, 0};
      tbl[6]  = '{0, 1, 1, 0, 0,  0, 0, 1, 0, 0};
      tbl[7]  = '{0, 1, 1, 0, 0,  0, 0, 0, 0, 1};
      tbl[8]  = '{0, 1, 1, 0, 0,  0, 0, 0, 0, 1};
      tbl[9]  = '{0, 1, 1, 0, 0,  0, 0, 0, 0, 1};
      tbl[10] = '{0, 1, 1, 0, 0,  0, 0, 0, 0, 1};
      tbl[11] = '{0, 1, 1, 0, 0,  0, 0, 0, 0, 1};
      tbl[12] = '{0, 1, 1, 0, 1,  0, 0, 0, 0, 1};
      tbl[13] = '{0, 1, 1, 0, 0,  1, 0, 0, 0, 0};
      tbl[14] = '{0, 0, 0, 0, 0,  0, 0, 1, 0, 0};
      tbl[15] = '{0, 0, 0, 1, 0,  0, 0, 0, 1, 0};
      tbl[16] = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0};
      tbl[17] = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0};

      step();
      step();

      for (int i = 0; i < 18; i++) begin
         ise_rst    = tbl[i].rst;
         r0_req_val = tbl[i].r0v;
         r1_req_val = tbl[i].r1v;
         r0_rsp_rdy = tbl[i].r0rr;
         r1_rsp_rdy = tbl[i].r1rr;
         #4;
         chk($sformatf("row%0d r0_req_rdy", i), r0_req_rdy, tbl[i].e0rdy);
         chk($sformatf("row%0d r1_req_rdy", i), r1_req_rdy, tbl[i].e1rdy);
         chk($sformatf("row%0d x_val", i), x_val, tbl[i].exval);
         chk($sformatf("row%0d r0_rsp_val", i), r0_rsp_val, tbl[i].e0val);
         chk($sformatf("row%0d r1_rsp_val", i), r1_rsp_val, tbl[i].e1val);
         chk($sformatf("row%0d r0_rsp_out", i), r0_rsp_out, tbl[i].e0val ? R0_RES : 64'd0);
         chk($sformatf("row%0d r0_rsp_err", i), r0_rsp_err, 1'b0);
         chk($sformatf("row%0d r1_rsp_out", i), r1_rsp_out, 64'd0);
         chk($sformatf("row%0d r1_rsp_err", i), r1_rsp_err, tbl[i].e1val);
         step();
      end

      // Reset while r1's op sits in EXEC; last-served is r0 at this point
      r1_req_val = 1;
      #4; chk("mid r1_req_rdy", r1_req_rdy, 1'b1);
      step();
      r1_req_val = 0; ise_rst = 1;
      #4; chk("mid exec x_val", x_val, 1'b1);
      step();
      ise_rst = 0;
      #4;
      chk("post rst x_val", x_val, 1'b0);
      chk("post rst r1_rsp_val", r1_rsp_val, 1'b0);
      chk("post rst r0_rsp_val", r0_rsp_val, 1'b0);
      chk("post rst x_in1", x_in1, 64'd0);
      chk("post rst x_fn", x_fn, 5'd0);
      step();
      #4; chk("post rst idle r1_rsp_val", r1_rsp_val, 1'b0);
      step();

      // Contested grant after reset goes to r0; then operand isolation
      a_val = 64'h0123456789ABCDEF; b_val = 64'hFEDCBA9876543210;
      r0_fn = 5'd2; r0_imm = 7'h11; r0_in1 = a_val; r0_in2 = b_val;
      r0_req_val = 1; r1_req_val = 1;
      #4;
      chk("rst grant r0_req_rdy", r0_req_rdy, 1'b1);
      chk("rst grant r1_req_rdy", r1_req_rdy, 1'b0);
      step();
      r0_req_val = 0; r1_req_val = 0; r0_in1 = ~a_val; r0_in2 = 64'd0; r0_fn = 5'd9;
      #4;
      chk("iso x_val", x_val, 1'b1);
      chk("iso x_in1", x_in1, a_val);
      chk("iso x_in2", x_in2, b_val);
      chk("iso x_fn", x_fn, 5'd2);
      step();
      r0_rsp_rdy = 1;
      #4;
      chk("iso r0_rsp_val", r0_rsp_val, 1'b1);
      chk("iso r0_rsp_out", r0_rsp_out, alu_ref(5'd2, 7'h11, a_val, b_val));
      step();
      r0_rsp_rdy = 0;
      #4;
      chk("iso idle r0_rsp_val", r0_rsp_val, 1'b0);
      chk("iso idle x_in1 held", x_in1, a_val);

      // Randomized run against the transaction model
      ise_rst = 1;
      step();
      m_busy = 0; m_owner = 0; m_last = 1; m_age = 0;
      m_fn = '0; m_imm = '0; m_in1 = '0; m_in2 = '0;
      for (int t = 0; t < 3000; t++) begin
         ise_rst    = ($urandom_range(0, 99) == 0);
         r0_req_val = ($urandom_range(0, 2) != 0);
         r1_req_val = ($urandom_range(0, 2) != 0);
         r0_rsp_rdy = $urandom_range(0, 1);
         r1_rsp_rdy = $urandom_range(0, 1);
         r0_fn  = 5'($urandom);
         r1_fn  = 5'($urandom);
         r0_imm = ($urandom_range(0, 5) == 0) ? 7'h7F : 7'($urandom_range(0, 126));
         r1_imm = ($urandom_range(0, 5) == 0) ? 7'h7F : 7'($urandom_range(0, 126));
         r0_in1 = {$urandom, $urandom}; r0_in2 = {$urandom, $urandom};
         r1_in1 = {$urandom, $urandom}; r1_in2 = {$urandom, $urandom};
         #4;
         g0   = !m_busy && r0_req_val && (!r1_req_val || m_last);
         g1   = !m_busy && r1_req_val && (!r0_req_val || !m_last);
         ev   = m_busy && (m_age == 1);
         rv   = m_busy && (m_age >= 2);
         eres = alu_ref(m_fn, m_imm, m_in1, m_in2);
         chk("rnd r0_req_rdy", r0_req_rdy, g0);
         chk("rnd r1_req_rdy", r1_req_rdy, g1);
         chk("rnd x_val", x_val, ev);
         chk("rnd x_in1", x_in1, m_in1);
         chk("rnd x_imm", x_imm, m_imm);
         chk("rnd r0_rsp_val", r0_rsp_val, rv && !m_owner);
         chk("rnd r1_rsp_val", r1_rsp_val, rv && m_owner);
         chk("rnd r0_rsp_out", r0_rsp_out, (rv && !m_owner) ? eres : 64'd0);
         chk("rnd r1_rsp_out", r1_rsp_out, (rv && m_owner) ? eres : 64'd0);
         chk("rnd r0_rsp_err", r0_rsp_err, rv && !m_owner && (m_imm == 7'h7F));
         chk("rnd r1_rsp_err", r1_rsp_err, rv && m_owner && (m_imm == 7'h7F));
         if (ise_rst) begin
            m_busy = 0; m_last = 1; m_age = 0;
            m_fn = '0; m_imm = '0; m_in1 = '0; m_in2 = '0;
         end else if (g0 || g1) begin
            m_busy = 1; m_owner = g1; m_age = 1;
            m_fn  = g1 ? r1_fn  : r0_fn;
            m_imm = g1 ? r1_imm : r0_imm;
            m_in1 = g1 ? r1_in1 : r0_in1;
            m_in2 = g1 ? r1_in2 : r0_in2;
         end else if (rv && (m_owner ? r1_rsp_rdy : r0_rsp_rdy)) begin
            m_busy = 0; m_last = m_owner;
         end else if (m_busy) begin
            m_age++;
         end
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
